// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and load/store (LS).
// LS has fixed priority; a starvation counter forces an IF grant after STARVE_MAX LS wins.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
    localparam int unsigned STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);
    localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    state_t            state_q,     state_d;
    owner_t            owner_q,     owner_d;
    logic              we_q,        we_d;
    logic [LAT_W-1:0]  lat_cnt_q,   lat_cnt_d;
    logic [STV_W-1:0]  starve_q,    starve_d;
    logic              if_gnt_q,    if_gnt_d;
    logic              ls_gnt_q,    ls_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q,  ls_rdata_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q,      busy_d;

    logic              ls_win;
    logic              if_win;
    logic [DATA_W-1:0] cap_data;

    always_comb begin
        ls_win = ls_req && !(if_req && (starve_q == STV_LIM));
        if_win = if_req && !ls_win;
    end

    // Gnt/mem/rvalid registers are loaded on the edge that enters their state,
    // so every output is a flop yet lines up with the matching FSM state.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        lat_cnt_d   = lat_cnt_q;
        starve_d    = starve_q;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cap_data    = '0;

        case (state_q)
            IDLE: begin
                if (ls_win && if_req) begin
                    starve_d = (starve_q == STV_LIM) ? starve_q : starve_q + STV_W'(1);
                end else begin
                    starve_d = '0;
                end
                if (ls_win || if_win) begin
                    state_d     = ISSUE;
                    owner_d     = ls_win ? OWN_LS : OWN_IF;
                    we_d        = ls_win && ls_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = ls_win && ls_we;
                    mem_addr_d  = ls_win ? ls_addr : if_addr;
                    mem_wdata_d = ls_win ? ls_wdata : '0;
                    if_gnt_d    = if_win;
                    ls_gnt_d    = ls_win;
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_INIT;
                state_d   = WAIT;
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    state_d  = RESP;
                    cap_data = we_q ? '0 : mem_rdata;
                    if (owner_q == OWN_LS) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = cap_data;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = cap_data;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            lat_cnt_q   <= '0;
            starve_q    <= '0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            lat_cnt_q   <= lat_cnt_d;
            starve_q    <= starve_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        if_gnt    = if_gnt_q;
        ls_gnt    = ls_gnt_q;
        if_rvalid = if_rvalid_q;
        ls_rvalid = ls_rvalid_q;
        if_rdata  = if_rdata_q;
        ls_rdata  = ls_rdata_q;
        mem_en    = mem_en_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
// One instance runs MEM_LAT=1 under the model; a second runs MEM_LAT=3 for latency checks.
module tb_mem_port_arbiter;

    localparam int L  = 1;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        if_req, if_gnt, if_rvalid, ls_req, ls_we, ls_gnt, ls_rvalid;
    logic        mem_en, mem_we, busy;
    logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        if_req3, if_gnt3, if_rvalid3, ls_req3, ls_we3, ls_gnt3, ls_rvalid3;
    logic        mem_en3, mem_we3, busy3;
    logic [31:0] if_addr3, if_rdata3, ls_addr3, ls_wdata3, ls_rdata3;
    logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SM)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SM)) u_dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
        .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3), .ls_rdata(ls_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    // Environment memory (16 words, indexed by addr[5:2]) and transaction-level model state.
    logic [31:0] mem [16];
    int          rd_cyc = -100;
    int          rd_idx = 0;
    bit          m_busy = 0;
    int          m_s    = 0;
    bit          m_own  = 0;
    bit          m_we   = 0;
    logic [31:0] m_addr, m_wdata, m_data;
    int          m_starve = 0;
    logic [31:0] l_maddr = '0, l_mwdata = '0, l_ifr = '0, l_lsr = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, k);
        end
    endfunction

    // Decide what the arbiter does with the requests sampled at the end of cycle k.
    task automatic advance();
        bit idle;
        bit lw;
        bit iw;
        idle = !m_busy || (k > m_s + L + 1);
        if (idle) begin
            m_busy = 0;
            lw = ls_req && !(if_req && m_starve == SM);
            iw = if_req && !lw;
            if (lw && if_req) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
            else              m_starve = 0;
            if (lw || iw) begin
                m_busy  = 1;
                m_s     = k + 1;
                m_own   = lw;
                m_we    = lw && ls_we;
                m_addr  = lw ? ls_addr : if_addr;
                m_wdata = lw ? ls_wdata : 32'h0;
                m_data  = m_we ? 32'h0 : mem[m_addr[5:2]];
            end
        end
    endtask

    task automatic check_cycle();
        bit iss;
        bit rsp;
        iss = m_busy && (k == m_s);
        rsp = m_busy && (k == m_s + L + 1);
        if (iss) begin
            l_maddr  = m_addr;
            l_mwdata = m_wdata;
        end
        if (rsp) begin
            if (m_own) l_lsr = m_data;
            else       l_ifr = m_data;
        end
        chk("cyc_if_gnt",    64'(if_gnt),    64'(iss && !m_own));
        chk("cyc_ls_gnt",    64'(ls_gnt),    64'(iss && m_own));
        chk("cyc_mem_en",    64'(mem_en),    64'(iss));
        chk("cyc_mem_we",    64'(mem_we),    64'(iss && m_own && m_we));
        chk("cyc_mem_addr",  64'(mem_addr),  64'(l_maddr));
        chk("cyc_mem_wdata", 64'(mem_wdata), 64'(l_mwdata));
        chk("cyc_if_rvalid", 64'(if_rvalid), 64'(rsp && !m_own));
        chk("cyc_ls_rvalid", 64'(ls_rvalid), 64'(rsp && m_own));
        chk("cyc_if_rdata",  64'(if_rdata),  64'(l_ifr));
        chk("cyc_ls_rdata",  64'(ls_rdata),  64'(l_lsr));
        chk("cyc_busy",      64'(busy),      64'(m_busy && k >= m_s && k <= m_s + L + 1));
    endtask

    // Memory macro: read data is valid only in the last latency cycle, garbage otherwise.
    task automatic memory();
        if (mem_en) begin
            if (mem_we) mem[mem_addr[5:2]] = mem_wdata;
            else begin
                rd_cyc = k + L;
                rd_idx = int'(mem_addr[5:2]);
            end
        end
        mem_rdata = (k == rd_cyc) ? mem[rd_idx] : $urandom;
    endtask

    task automatic cycle();
        advance();
        @(negedge clk);
        k++;
        check_cycle();
        memory();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_busy",   64'(busy),     64'd0);
        chk("rst_gnt",    64'({if_gnt, ls_gnt}), 64'd0);
        chk("rst_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        chk("rst_mem",    64'({mem_en, mem_we}), 64'd0);
        chk("rst_addr",   64'(mem_addr), 64'd0);
        chk("rst_rdata",  64'(if_rdata | ls_rdata), 64'd0);
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
        k++;
        #1 reset = 1'b0;
        m_busy = 0; m_starve = 0; rd_cyc = -100;
        l_maddr = '0; l_mwdata = '0; l_ifr = '0; l_lsr = '0;
    endtask

    task automatic if_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data);
        int k0, g, r;
        logic [31:0] d;
        logic en;
        g = -100; r = -100; d = '0; en = 1'b0;
        k0 = k;
        if_req = 1'b1; if_addr = addr;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (if_gnt) begin g = k; en = mem_en; if_req = 1'b0; end
            if (if_rvalid) begin r = k; d = if_rdata; break; end
        end
        chk({tag, "_gnt_lat"}, 64'(g - k0), 64'd1);
        chk({tag, "_mem_en"},  64'(en), 64'd1);
        chk({tag, "_rv_lat"},  64'(r - g), 64'd2);
        chk({tag, "_data"},    64'(d), 64'(exp_data));
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g, r, c, bcnt, ifrv, wcnt, n;
        logic [31:0] d, wa, wd;
        logic [5:0]  seq;
        bit if_pend, ls_pend;

        reset = 1'b1;
        if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
        if_req3 = 0; if_addr3 = '0; ls_req3 = 0; ls_we3 = 0; ls_addr3 = '0; ls_wdata3 = '0; mem_rdata3 = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        repeat (3) @(negedge clk);
        chk("reset_busy",   64'({busy, busy3}), 64'd0);
        chk("reset_gnt",    64'({if_gnt, ls_gnt, if_gnt3, ls_gnt3}), 64'd0);
        chk("reset_rvalid", 64'({if_rvalid, ls_rvalid, if_rvalid3, ls_rvalid3}), 64'd0);
        chk("reset_mem",    64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'd0);
        chk("reset_rdata",  64'({if_rdata, ls_rdata}), 64'd0);
        #1 reset = 1'b0;

        // MEM_LAT=3 load: rvalid 4 cycles after gnt, busy for 5 cycles.
        g = -100; r = -100; c = 0; bcnt = 0; ifrv = 0; d = '0;
        ls_req3 = 1'b1; ls_addr3 = 32'h8;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            c++;
            if (busy3) bcnt++;
            if (if_rvalid3) ifrv++;
            if (ls_gnt3) begin g = c; ls_req3 = 1'b0; end
            if (ls_rvalid3) begin r = c; d = ls_rdata3; end
            mem_rdata3 = (g >= 0 && c == g + 3) ? 32'hCAFE0005 : $urandom;
            if (r >= 0 && c > r) break;
        end
        chk("t5_rv_lat",   64'(r - g), 64'd4);
        chk("t5_data",     64'(d), 64'hCAFE0005);
        chk("t5_busy_cnt", 64'(bcnt), 64'd5);
        chk("t5_busy_end", 64'(busy3), 64'd0);
        chk("t5_no_if_rv", 64'(ifrv), 64'd0);

        // Single IF fetch.
        mem[4] = 32'h00A00093;
        if_read("t1", 32'h10, 32'h00A00093);

        // Simultaneous requests: LS load wins, IF granted at the IDLE after RESP.
        mem[0] = 32'h1E;
        g = -100; r = -100; n = -100; d = '0;
        c = k;
        if_req = 1'b1; if_addr = 32'h20; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (ls_gnt) begin g = k; ls_req = 1'b0; end
            if (if_gnt) begin n = k; if_req = 1'b0; break; end
            if (ls_rvalid) begin r = k; d = ls_rdata; end
        end
        chk("t2_ls_gnt_lat", 64'(g - c), 64'd1);
        chk("t2_ls_data",    64'(d), 64'h1E);
        chk("t2_if_after",   64'(n - r), 64'd2);
        repeat (4) cycle();

        // Store: one mem_we cycle, ack with zero data, no IF response.
        wcnt = 0; wa = '0; wd = '0; ifrv = 0; r = 0; d = 32'hFFFFFFFF;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h4; ls_wdata = 32'h14;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (ls_gnt) ls_req = 1'b0;
            if (mem_we) begin wcnt++; wa = mem_addr; wd = mem_wdata; end
            if (if_rvalid) ifrv++;
            if (ls_rvalid) begin r++; d = ls_rdata; end
        end
        chk("t3_we_cnt", 64'(wcnt), 64'd1);
        chk("t3_addr",   64'(wa), 64'h4);
        chk("t3_wdata",  64'(wd), 64'h14);
        chk("t3_ack",    64'(r), 64'd1);
        chk("t3_rdata",  64'(d), 64'd0);
        chk("t3_no_if",  64'(ifrv), 64'd0);
        ls_we = 1'b0;

        // Starvation: both held continuously.
        seq = '0; n = 0;
        if_req = 1'b1; if_addr = 32'h30; ls_req = 1'b1; ls_addr = 32'h8;
        for (int i = 0; i < 60 && n < 6; i++) begin
            cycle();
            if (if_gnt || ls_gnt) begin seq = {seq[4:0], ls_gnt}; n++; end
        end
        chk("t4_grants", 64'(seq), 64'b111101);
        if_req = 1'b0; ls_req = 1'b0;
        repeat (6) cycle();

        // Reset during WAIT: no rvalid afterwards, then a normal fetch.
        g = -100;
        if_req = 1'b1; if_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (if_gnt) begin g = k; if_req = 1'b0; break; end
        end
        cycle();
        chk("t6_in_wait", 64'(k - g), 64'd1);
        do_reset();
        r = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (if_rvalid || ls_rvalid) r++;
        end
        chk("t6_no_rv", 64'(r), 64'd0);
        if_read("t6", 32'h10, mem[4]);

        // Randomized traffic with occasional resets.
        if_pend = 0; ls_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            if (if_gnt) if_pend = 0;
            if (ls_gnt) ls_pend = 0;
            if (!if_pend) begin
                if_addr = $urandom;
                if_pend = ($urandom_range(0, 2) == 0);
            end
            if (!ls_pend) begin
                ls_addr  = $urandom;
                ls_wdata = $urandom;
                ls_we    = 1'($urandom);
                ls_pend  = ($urandom_range(0, 3) < ((i < 1500) ? 3 : 1));
            end
            if_req = if_pend;
            ls_req = ls_pend;
            cycle();
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                if_pend = 0;
                ls_pend = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
